// File: rtl/interboard_pkg.sv
// interboard_pkg: shared message layout, FSM states and msg_type codes for the interboard link
package interboard_pkg;
  localparam int NUM_W = 5;
  localparam int TYPE_W = 3;
  typedef struct packed {
    logic [NUM_W-1:0]  number;
    logic [TYPE_W-1:0] msg_type;
  } interboard_msg_t;
  typedef enum logic [1:0] {IDLE, HOLD, WAIT_READY} tx_state_t;
  localparam logic [TYPE_W-1:0] MSG_NOP    = 3'b000;
  localparam logic [TYPE_W-1:0] MSG_MOVE   = 3'b001;
  localparam logic [TYPE_W-1:0] MSG_ATTACK = 3'b010;
  localparam logic [TYPE_W-1:0] MSG_SCORE  = 3'b011;
  localparam logic [TYPE_W-1:0] MSG_TURN   = 3'b100;
  localparam logic [TYPE_W-1:0] MSG_RESET  = 3'b111;
endpackage

// File: rtl/interboard_msg_fifo.sv
// interboard_msg_fifo: synchronous FIFO of interboard messages; ports: clk, flush_i, push_i, pop_i, data_i -> data_o (head), full_o, empty_o, count_o
module interboard_msg_fifo
  import interboard_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  interboard_msg_t          data_i,
  output interboard_msg_t          data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  interboard_msg_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic wr_en, rd_en;
  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign rd_en   = pop_i && !empty_o;
  // A pop in the same cycle frees a slot, so a push at full is still accepted
  assign wr_en   = push_i && (!full_o || rd_en);
  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= data_i;
  end
  always_ff @(posedge clk) begin
    if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (rd_en) rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(wr_en) - CW'(rd_en);
    end
  end
endmodule

// File: rtl/interboard_tx_queue.sv
// interboard_tx_queue: buffers GameControl messages and issues one ctrl_en per message while this board owns the link; ports: clk, rst, interboard_rst, push/push_number/push_msg_type, transmit, inter_ready -> ctrl_en/ctrl_number/ctrl_msg_type, full, empty, count, overflow, busy
module interboard_tx_queue
  import interboard_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int GUARD = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   interboard_rst,
  input  logic                   push,
  input  logic [NUM_W-1:0]       push_number,
  input  logic [TYPE_W-1:0]      push_msg_type,
  input  logic                   transmit,
  input  logic                   inter_ready,
  output logic                   ctrl_en,
  output logic [NUM_W-1:0]       ctrl_number,
  output logic [TYPE_W-1:0]      ctrl_msg_type,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   busy
);
  localparam int GW = $clog2(GUARD + 1);
  tx_state_t state_q, state_d;
  logic [GW-1:0] guard_q, guard_d;
  logic ctrl_en_q, overflow_q, overflow_d, flush, issue;
  interboard_msg_t ctrl_q, head, push_msg;
  assign flush    = rst | interboard_rst;
  assign push_msg = '{number: push_number, msg_type: push_msg_type};
  assign issue    = state_q == IDLE && transmit && inter_ready && !empty;
  interboard_msg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (issue),
    .data_i  (push_msg),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  always_comb begin
    state_d    = state_q == IDLE ? (issue ? HOLD : IDLE)
               : state_q == HOLD ? (guard_q == '0 ? WAIT_READY : HOLD)
               : (inter_ready ? IDLE : WAIT_READY);
    guard_d    = issue ? GW'(GUARD - 1) : state_q == HOLD ? guard_q - GW'(1) : guard_q;
    overflow_d = overflow_q | (push & full & ~issue);
  end
  always_ff @(posedge clk) begin
    if (flush) begin
      state_q   <= IDLE;
      guard_q   <= '0;
      ctrl_en_q <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      guard_q   <= guard_d;
      ctrl_en_q <= issue;
      if (issue) ctrl_q <= head;
    end
  end
  // The other board's reset flushes the queue but keeps the local drop diagnostic
  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else if (!interboard_rst) overflow_q <= overflow_d;
  end
  assign ctrl_en       = ctrl_en_q;
  assign ctrl_number   = ctrl_q.number;
  assign ctrl_msg_type = ctrl_q.msg_type;
  assign overflow      = overflow_q;
  assign busy          = state_q != IDLE;
endmodule

// File: tb/tb_interboard_tx_queue.sv
// tb_interboard_tx_queue: scoreboard bench for interboard_tx_queue
module tb_interboard_tx_queue;
  localparam int DEPTH = 8;
  localparam int GUARD = 2;
  logic clk = 1'b0;
  logic rst, interboard_rst, push, transmit, inter_ready;
  logic [4:0] push_number;
  logic [2:0] push_msg_type;
  logic ctrl_en, full, empty, overflow, busy;
  logic [4:0] ctrl_number;
  logic [2:0] ctrl_msg_type;
  logic [3:0] count;
  int checks = 0, errors = 0, cyc = 0, pulses = 0, last_pulse = -1;
  logic [7:0] exp_q [$];

  interboard_tx_queue #(.DEPTH(DEPTH), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .interboard_rst(interboard_rst), .push(push),
    .push_number(push_number), .push_msg_type(push_msg_type), .transmit(transmit),
    .inter_ready(inter_ready), .ctrl_en(ctrl_en), .ctrl_number(ctrl_number),
    .ctrl_msg_type(ctrl_msg_type), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst || interboard_rst) last_pulse = -1;
    if (ctrl_en) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: unexpected pulse got %0d/%0d, required none", ctrl_number, ctrl_msg_type);
      end else begin
        if ({ctrl_number, ctrl_msg_type} !== exp_q[0]) begin
          errors++;
          $display("FAIL scoreboard: got %0d/%0d, required %0d/%0d", ctrl_number, ctrl_msg_type, exp_q[0][7:3], exp_q[0][2:0]);
        end
        void'(exp_q.pop_front());
      end
      if (last_pulse >= 0) begin
        checks++;
        if (cyc - last_pulse < GUARD + 2) begin
          errors++;
          $display("FAIL pulse_spacing: got %0d, required >= %0d", cyc - last_pulse, GUARD + 2);
        end
      end
      last_pulse = cyc;
    end
  end

  task automatic push_one(input logic [4:0] n, input logic [2:0] t);
    push = 1'b1;
    push_number = n;
    push_msg_type = t;
    if (exp_q.size() < DEPTH) exp_q.push_back({n, t});
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    bit done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      if (exp_q.size() == 0 && !busy && empty) done = 1;
      else @(negedge clk);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks += 8;
    if (ctrl_en !== 1'b0) begin errors++; $display("FAIL rst_ctrl_en: got %b, required 0", ctrl_en); end
    if (ctrl_number !== 5'd0) begin errors++; $display("FAIL rst_number: got %0d, required 0", ctrl_number); end
    if (ctrl_msg_type !== 3'd0) begin errors++; $display("FAIL rst_type: got %0d, required 0", ctrl_msg_type); end
    if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b, required 0", full); end
    if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b, required 1", empty); end
    if (count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d, required 0", count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
  endtask

  task automatic test_issue();
    transmit = 1'b1;
    inter_ready = 1'b1;
    push_one(5'd7, 3'b010);
    checks += 2;
    if (ctrl_en !== 1'b0) begin errors++; $display("FAIL issue_early: got %b, required 0", ctrl_en); end
    if (count !== 4'd1) begin errors++; $display("FAIL issue_count1: got %0d, required 1", count); end
    @(negedge clk);
    checks += 5;
    if (ctrl_en !== 1'b1) begin errors++; $display("FAIL issue_pulse: got %b, required 1", ctrl_en); end
    if (ctrl_number !== 5'd7) begin errors++; $display("FAIL issue_number: got %0d, required 7", ctrl_number); end
    if (ctrl_msg_type !== 3'd2) begin errors++; $display("FAIL issue_type: got %0d, required 2", ctrl_msg_type); end
    if (count !== 4'd0) begin errors++; $display("FAIL issue_count0: got %0d, required 0", count); end
    if (busy !== 1'b1) begin errors++; $display("FAIL issue_busy: got %b, required 1", busy); end
    @(negedge clk);
    checks += 2;
    if (ctrl_en !== 1'b0) begin errors++; $display("FAIL issue_one_cycle: got %b, required 0", ctrl_en); end
    if (ctrl_number !== 5'd7) begin errors++; $display("FAIL issue_hold_number: got %0d, required 7", ctrl_number); end
    wait_drain(20);
  endtask

  task automatic test_back_to_back();
    int p0 = pulses, pl = pulses, d = -100;
    transmit = 1'b1;
    inter_ready = 1'b1;
    push_one(5'd1, 3'd1);
    push_one(5'd2, 3'd1);
    push_one(5'd3, 3'd1);
    for (int k = 0; k < 80 && !(pulses == p0 + 3 && !busy); k++) begin
      if (pulses != pl) begin pl = pulses; d = k + 1; end
      if (k == d) inter_ready = 1'b0;
      if (k == d + 3) inter_ready = 1'b1;
      @(negedge clk);
    end
    inter_ready = 1'b1;
    checks++;
    if (pulses - p0 !== 3) begin errors++; $display("FAIL b2b_pulses: got %0d, required 3", pulses - p0); end
    wait_drain(20);
  endtask

  task automatic test_gate();
    int p0 = pulses;
    transmit = 1'b0;
    inter_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_one(5'(10 + i), 3'(i));
    repeat (5) @(negedge clk);
    checks += 2;
    if (pulses !== p0) begin errors++; $display("FAIL gate_pulses: got %0d, required %0d", pulses, p0); end
    if (count !== 4'd4) begin errors++; $display("FAIL gate_count: got %0d, required 4", count); end
    transmit = 1'b1;
    wait_drain(60);
    checks++;
    if (pulses - p0 !== 4) begin errors++; $display("FAIL gate_issued: got %0d, required 4", pulses - p0); end
  endtask

  task automatic test_full();
    transmit = 1'b0;
    inter_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_one(5'(20 + i), 3'(7 - i));
    checks += 3;
    if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b, required 1", full); end
    if (count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d, required 8", count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL full_no_overflow: got %b, required 0", overflow); end
    transmit = 1'b1;
    push = 1'b1;
    push_number = 5'd31;
    push_msg_type = 3'd7;
    exp_q.push_back({5'd31, 3'd7});
    @(negedge clk);
    push = 1'b0;
    transmit = 1'b0;
    checks += 3;
    if (ctrl_en !== 1'b1) begin errors++; $display("FAIL full_pop_pulse: got %b, required 1", ctrl_en); end
    if (count !== 4'd8) begin errors++; $display("FAIL full_pushpop_count: got %0d, required 8", count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_overflow: got %b, required 0", overflow); end
    push_one(5'd30, 3'd5);
    checks += 2;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b, required 1", overflow); end
    if (count !== 4'd8) begin errors++; $display("FAIL overflow_count: got %0d, required 8", count); end
    transmit = 1'b1;
    wait_drain(100);
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL full_drained: got %0d, required 0", count); end
  endtask

  task automatic test_flush();
    int p0;
    transmit = 1'b0;
    inter_ready = 1'b1;
    push_one(5'd4, 3'd1);
    push_one(5'd5, 3'd2);
    push_one(5'd6, 3'd3);
    transmit = 1'b1;
    @(negedge clk);
    inter_ready = 1'b0;
    transmit = 1'b0;
    checks++;
    if (ctrl_en !== 1'b1) begin errors++; $display("FAIL flush_pulse: got %b, required 1", ctrl_en); end
    repeat (2) @(negedge clk);
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL flush_wait_busy: got %b, required 1", busy); end
    if (count !== 4'd2) begin errors++; $display("FAIL flush_pre_count: got %0d, required 2", count); end
    interboard_rst = 1'b1;
    exp_q.delete();
    p0 = pulses;
    @(negedge clk);
    interboard_rst = 1'b0;
    checks += 6;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle: got %b, required 0", busy); end
    if (count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d, required 0", count); end
    if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b, required 1", empty); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL flush_overflow_kept: got %b, required 1", overflow); end
    if (ctrl_en !== 1'b0) begin errors++; $display("FAIL flush_ctrl_en: got %b, required 0", ctrl_en); end
    if (ctrl_number !== 5'd0) begin errors++; $display("FAIL flush_number: got %0d, required 0", ctrl_number); end
    inter_ready = 1'b1;
    transmit = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (pulses !== p0) begin errors++; $display("FAIL flush_no_issue: got %0d, required %0d", pulses, p0); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL rst_clears_overflow: got %b, required 0", overflow); end
  endtask

  task automatic test_wrap();
    int p0 = pulses;
    transmit = 1'b1;
    inter_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      int w = 0;
      push_one(5'((i * 3 + 1) % 32), 3'(i % 8));
      while (pulses < p0 + i + 1 && w < 20) begin @(negedge clk); w++; end
      checks++;
      if (pulses < p0 + i + 1) begin errors++; $display("FAIL wrap_issue_%0d: got %0d pulses, required %0d", i, pulses - p0, i + 1); end
    end
    wait_drain(20);
  endtask

  initial begin
    rst = 1'b0; interboard_rst = 1'b0; push = 1'b0; push_number = '0; push_msg_type = '0;
    transmit = 1'b0; inter_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_issue();
    test_back_to_back();
    test_gate();
    test_full();
    test_flush();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end
endmodule
